// File: rtl/ctrl_unit_mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit:
// state codes, opcode/funct values and datapath mux selections.
package ctrl_unit_mc_pkg;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_R     = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_WB_LD    = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_OVF      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_RST   = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  localparam logic [2:0] PCS_ALU = 3'b000;
  localparam logic [2:0] PCS_OUT = 3'b001;
  localparam logic [2:0] PCS_JMP = 3'b010;
  localparam logic [2:0] PCS_EXC = 3'b100;

  localparam logic [2:0] IORD_PC  = 3'b000;
  localparam logic [2:0] IORD_ALU = 3'b001;

  localparam logic [1:0] SRCA_PC  = 2'b00;
  localparam logic [1:0] SRCA_A   = 2'b01;
  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BRA = 2'b11;

  localparam logic [3:0] DS_ALUOUT = 4'b0000;
  localparam logic [3:0] DS_MDR    = 4'b0001;

  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    unique case (fn)
      FN_ADD:  r_alu = ALU_ADD;
      FN_SUB:  r_alu = ALU_SUB;
      FN_AND:  r_alu = ALU_AND;
      default: r_alu = ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_unit_mc_wait_cnt.sv
// Memory wait-state counter; done marks the last cycle of an access.
// Shared by instruction fetch, load and store.
module ctrl_wait_cnt
  import ctrl_unit_mc_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam logic [2:0] WMAX = 3'(MEM_WAIT);

  logic [2:0] cnt;

  assign done = (cnt == WMAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 3'd0;
    end else if (clr) begin
      cnt <= 3'd0;
    end else if (en && !done) begin
      cnt <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/ctrl_unit_mc.sv
// Multicycle control FSM for the MIPS-subset datapath.
// Outputs decode from the state register; illegal is a registered pulse.
module ctrl_unit_mc
  import ctrl_unit_mc_pkg::*;
#(
  parameter int MEM_WAIT = 2,
  parameter int OVF_TRAP = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       Eq,
  input  logic       Ofw,
  output logic       PC_Write,
  output logic [2:0] IorD,
  output logic       MEM_write_or_read,
  output logic       IR_Write,
  output logic       MDR_Write,
  output logic       AB_Write,
  output logic       RegWrite,
  output logic       EPC_Write,
  output logic [1:0] RegDst,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUCtrl,
  output logic       ALUOutCtrl,
  output logic [2:0] PCSource,
  output logic [3:0] DataSrc,
  output logic       illegal,
  output logic       reset_out
);

  state_t state, state_nxt;
  logic   wdone;
  logic   ill_q;
  logic   is_r, is_i, is_mem, is_br, is_j, is_rst, dec_ill;
  logic   trap_en;

  assign is_r = (OPCODE == OP_RTYPE) &&
                (FUNCT == FN_ADD || FUNCT == FN_SUB ||
                 FUNCT == FN_AND);
  assign is_i   = (OPCODE == OP_ADDI);
  assign is_mem = (OPCODE == OP_LW) || (OPCODE == OP_SW);
  assign is_br  = (OPCODE == OP_BEQ) || (OPCODE == OP_BNE);
  assign is_j   = (OPCODE == OP_J);
  assign is_rst = (OPCODE == OP_RST);
  assign dec_ill = !(is_r || is_i || is_mem ||
                     is_br || is_j || is_rst);

  // AND never overflows, so it is never trapped
  assign trap_en = (OVF_TRAP != 0) && Ofw;

  ctrl_wait_cnt #(
    .MEM_WAIT(MEM_WAIT)
  ) u_wait (
    .clk  (clk),
    .reset(reset),
    .clr  (state_nxt != state),
    .en   (state == S_FETCH || state == S_MEM_RD ||
           state == S_MEM_WR),
    .done (wdone)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_RESET;
      ill_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ill_q <= (state == S_DECODE) && dec_ill;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_RESET: state_nxt = S_FETCH;
      S_FETCH:
        if (wdone) state_nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_r:    state_nxt = S_EXEC_R;
          is_i:    state_nxt = S_EXEC_I;
          is_mem:  state_nxt = S_MEM_ADDR;
          is_br:   state_nxt = S_BRANCH;
          is_j:    state_nxt = S_JUMP;
          is_rst:  state_nxt = S_RESET;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_EXEC_R:
        state_nxt = (trap_en && FUNCT != FN_AND) ?
                    S_OVF : S_WB_R;
      S_EXEC_I:
        state_nxt = trap_en ? S_OVF : S_WB_I;
      S_MEM_ADDR:
        state_nxt = (OPCODE == OP_LW) ?
                    S_MEM_RD : S_MEM_WR;
      S_MEM_RD:
        if (wdone) state_nxt = S_WB_LD;
      S_MEM_WR:
        if (wdone) state_nxt = S_FETCH;
      S_WB_R, S_WB_I, S_WB_LD,
      S_BRANCH, S_JUMP, S_OVF:
        state_nxt = S_FETCH;
      default: state_nxt = S_RESET;
    endcase
  end

  always_comb begin
    PC_Write          = 1'b0;
    IorD              = IORD_PC;
    MEM_write_or_read = 1'b0;
    IR_Write          = 1'b0;
    MDR_Write         = 1'b0;
    AB_Write          = 1'b0;
    RegWrite          = 1'b0;
    EPC_Write         = 1'b0;
    RegDst            = 2'b00;
    ALUSrcA           = SRCA_PC;
    ALUSrcB           = SRCB_B;
    ALUCtrl           = ALU_PASS;
    ALUOutCtrl        = 1'b0;
    PCSource          = PCS_ALU;
    DataSrc           = DS_ALUOUT;
    illegal           = ill_q;
    reset_out         = 1'b0;
    unique case (state)
      S_RESET: reset_out = 1'b1;
      S_FETCH: begin
        ALUSrcB = SRCB_4;
        ALUCtrl = ALU_ADD;
        PC_Write = wdone;
        IR_Write = wdone;
      end
      S_DECODE: begin
        AB_Write   = 1'b1;
        ALUOutCtrl = 1'b1;
        ALUSrcB    = SRCB_BRA;
        ALUCtrl    = ALU_ADD;
      end
      S_EXEC_R: begin
        ALUSrcA    = SRCA_A;
        ALUCtrl    = r_alu(FUNCT);
        ALUOutCtrl = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        ALUCtrl    = ALU_ADD;
        ALUOutCtrl = 1'b1;
      end
      S_WB_R: begin
        RegDst   = 2'b01;
        RegWrite = 1'b1;
      end
      S_WB_I: RegWrite = 1'b1;
      S_MEM_RD: begin
        IorD      = IORD_ALU;
        MDR_Write = wdone;
      end
      S_WB_LD: begin
        DataSrc  = DS_MDR;
        RegWrite = 1'b1;
      end
      S_MEM_WR: begin
        IorD              = IORD_ALU;
        MEM_write_or_read = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = SRCA_A;
        ALUCtrl  = ALU_SUB;
        PCSource = PCS_OUT;
        PC_Write = (OPCODE == OP_BNE) ? !Eq : Eq;
      end
      S_JUMP: begin
        PCSource = PCS_JMP;
        PC_Write = 1'b1;
      end
      S_OVF: begin
        EPC_Write = 1'b1;
        PCSource  = PCS_EXC;
        PC_Write  = 1'b1;
      end
      default: reset_out = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ctrl_unit_mc.sv
// Directed bench for ctrl_unit_mc: three instances cover
// MEM_WAIT=2/OVF_TRAP=1, MEM_WAIT=2/OVF_TRAP=0 and MEM_WAIT=0.
module tb_ctrl_unit_mc;

  typedef struct packed {
    logic       pc_write;
    logic [2:0] iord;
    logic       mem_wr;
    logic       ir_write;
    logic       mdr_write;
    logic       ab_write;
    logic       reg_write;
    logic       epc_write;
    logic [1:0] reg_dst;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] alu_ctrl;
    logic       alu_out;
    logic [2:0] pc_src;
    logic [3:0] data_src;
    logic       illegal;
    logic       rst_out;
  } out_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] OPCODE = 6'd0;
  logic [5:0] FUNCT = 6'd0;
  logic       Eq = 1'b0;
  logic       Ofw = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wire out_t ob;
    ctrl_unit_mc #(
      .MEM_WAIT((g == 2) ? 0 : 2),
      .OVF_TRAP((g == 1) ? 0 : 1)
    ) u_dut (
      .clk              (clk),
      .reset            (reset),
      .OPCODE           (OPCODE),
      .FUNCT            (FUNCT),
      .Eq               (Eq),
      .Ofw              (Ofw),
      .PC_Write         (ob.pc_write),
      .IorD             (ob.iord),
      .MEM_write_or_read(ob.mem_wr),
      .IR_Write         (ob.ir_write),
      .MDR_Write        (ob.mdr_write),
      .AB_Write         (ob.ab_write),
      .RegWrite         (ob.reg_write),
      .EPC_Write        (ob.epc_write),
      .RegDst           (ob.reg_dst),
      .ALUSrcA          (ob.src_a),
      .ALUSrcB          (ob.src_b),
      .ALUCtrl          (ob.alu_ctrl),
      .ALUOutCtrl       (ob.alu_out),
      .PCSource         (ob.pc_src),
      .DataSrc          (ob.data_src),
      .illegal          (ob.illegal),
      .reset_out        (ob.rst_out)
    );
  end

  out_t o0, o1, o2;
  assign o0 = g_dut[0].ob;
  assign o1 = g_dut[1].ob;
  assign o2 = g_dut[2].ob;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // leaves every instance in its first FETCH cycle
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_async", 8'(o0.rst_out), 8'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_cycle", 8'(o0.rst_out), 8'd1);
    step();
    chk("fetch_rst", 8'(o0.rst_out), 8'd0);
    chk("fetch_srcb", 8'(o0.src_b), 8'd1);
  endtask

  initial begin
    #2;
    do_reset();
    chk("rst_we", 8'(o0.pc_write | o0.reg_write), 8'd0);

    // ADD $3,$1,$2 with two wait states
    OPCODE = 6'b000000;
    FUNCT  = 6'b100000;
    chk("add_f1_ir", 8'(o0.ir_write), 8'd0);
    step();
    chk("add_f2_ir", 8'(o0.ir_write), 8'd0);
    step();
    chk("add_f3_ir", 8'(o0.ir_write), 8'd1);
    chk("add_f3_pcw", 8'(o0.pc_write), 8'd1);
    step();
    chk("add_dec_ab", 8'(o0.ab_write), 8'd1);
    chk("add_dec_srcb", 8'(o0.src_b), 8'd3);
    step();
    chk("add_ex_alu", 8'(o0.alu_ctrl), 8'd1);
    chk("add_ex_srca", 8'(o0.src_a), 8'd1);
    step();
    chk("add_wb_rw", 8'(o0.reg_write), 8'd1);
    chk("add_wb_dst", 8'(o0.reg_dst), 8'd1);
    step();
    chk("add_done", 8'(o0.reg_write), 8'd0);

    // reset in the middle of a load
    do_reset();
    OPCODE = 6'b100011;
    repeat (3) step();
    step();
    chk("lw_ma_srcb", 8'(o0.src_b), 8'd2);
    chk("lw_ma_aout", 8'(o0.alu_out), 8'd1);
    step();
    chk("lw_rd_iord", 8'(o0.iord), 8'd1);
    chk("lw_rd1_mdr", 8'(o0.mdr_write), 8'd0);
    step();
    reset = 1'b0;
    #1;
    chk("mid_iord", 8'(o0.iord), 8'd0);
    chk("mid_rstout", 8'(o0.rst_out), 8'd1);
    do_reset();

    // ADDI with overflow: trap vs. no-trap build
    OPCODE = 6'b001000;
    repeat (3) step();
    step();
    chk("addi_srcb", 8'(o0.src_b), 8'd2);
    Ofw = 1'b1;
    step();
    Ofw = 1'b0;
    chk("ovf_epc", 8'(o0.epc_write), 8'd1);
    chk("ovf_pcs", 8'(o0.pc_src), 8'd4);
    chk("ovf_pcw", 8'(o0.pc_write), 8'd1);
    chk("ovf_rw", 8'(o0.reg_write), 8'd0);
    chk("nt_rw", 8'(o1.reg_write), 8'd1);
    chk("nt_epc", 8'(o1.epc_write), 8'd0);
    chk("nt_dst", 8'(o1.reg_dst), 8'd0);
    step();
    chk("ovf_done", 8'(o0.epc_write), 8'd0);

    // AND never traps
    do_reset();
    FUNCT  = 6'b100100;
    OPCODE = 6'b000000;
    repeat (4) step();
    chk("and_alu", 8'(o0.alu_ctrl), 8'd3);
    Ofw = 1'b1;
    step();
    Ofw = 1'b0;
    chk("and_rw", 8'(o0.reg_write), 8'd1);
    chk("and_epc", 8'(o0.epc_write), 8'd0);

    // illegal opcode
    do_reset();
    OPCODE = 6'b010000;
    repeat (3) step();
    chk("ill_dec", 8'(o0.illegal), 8'd0);
    step();
    chk("ill_pulse", 8'(o0.illegal), 8'd1);
    chk("ill_we", 8'({o0.ir_write, o0.ab_write,
        o0.reg_write, o0.pc_write}), 8'd0);
    chk("ill_fetch", 8'(o0.src_b), 8'd1);
    step();
    chk("ill_end", 8'(o0.illegal), 8'd0);

    // zero wait states: LW
    do_reset();
    OPCODE = 6'b100011;
    chk("w0_f_ir", 8'(o2.ir_write), 8'd1);
    step();
    step();
    chk("w0_ma_aout", 8'(o2.alu_out), 8'd1);
    step();
    chk("w0_lw_mdr", 8'(o2.mdr_write), 8'd1);
    chk("w0_lw_iord", 8'(o2.iord), 8'd1);
    step();
    chk("w0_ld_rw", 8'(o2.reg_write), 8'd1);
    chk("w0_ld_ds", 8'(o2.data_src), 8'd1);
    chk("w0_ld_dst", 8'(o2.reg_dst), 8'd0);
    step();
    chk("w0_ld_done", 8'(o2.reg_write), 8'd0);

    // zero wait states: SW
    do_reset();
    OPCODE = 6'b101011;
    repeat (3) step();
    chk("sw_wr", 8'(o2.mem_wr), 8'd1);
    chk("sw_iord", 8'(o2.iord), 8'd1);
    step();
    chk("sw_wr_end", 8'(o2.mem_wr), 8'd0);

    // BEQ / BNE
    do_reset();
    OPCODE = 6'b000100;
    Eq = 1'b0;
    repeat (2) step();
    chk("beq_n_pcw", 8'(o2.pc_write), 8'd0);
    chk("beq_alu", 8'(o2.alu_ctrl), 8'd2);
    Eq = 1'b1;
    #1;
    chk("beq_y_pcw", 8'(o2.pc_write), 8'd1);
    Eq = 1'b0;
    do_reset();
    OPCODE = 6'b000101;
    repeat (2) step();
    chk("bne_pcw", 8'(o2.pc_write), 8'd1);
    chk("bne_pcs", 8'(o2.pc_src), 8'd1);

    // J
    do_reset();
    OPCODE = 6'b000010;
    repeat (2) step();
    chk("j_pcs", 8'(o2.pc_src), 8'd2);
    chk("j_pcw", 8'(o2.pc_write), 8'd1);

    // SUB and the 111111 reset opcode
    do_reset();
    OPCODE = 6'b000000;
    FUNCT  = 6'b100010;
    repeat (2) step();
    chk("sub_alu", 8'(o2.alu_ctrl), 8'd2);
    do_reset();
    OPCODE = 6'b111111;
    repeat (2) step();
    chk("op_rst", 8'(o2.rst_out), 8'd1);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
